imem_sync: RTL

Parametrised, synchronous-read instruction memory for the MIPS datapath: byte-addressed word fetch with a one-cycle registered read, a loader write port, and fault flagging for misaligned or out-of-range addresses. After reset, a built-in clear sequencer zeroes the array before the memory accepts fetches. It sits between the PC/fetch stage and the instruction register, and doubles as the program-load target for the bench or a boot loader.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_array.sv | 31 +++
 rtl/imem_sync.sv | 136 +++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory: state encoding, byte-offset
// width and the address decode helpers used by imem_sync.
package imem_pkg;

    localparam int unsigned BYTE_OFF_W = 2;

    typedef enum logic {
        IMEM_CLEAR = 1'b0,
        IMEM_READY = 1'b1
    } imem_state_e;

    // Addresses are widened to 64 bits by the caller so one helper serves any ADDR_W.
    function automatic logic [63:0] word_index(input logic [63:0] addr,
                                               input int unsigned idx_w);
        return (addr >> BYTE_OFF_W) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic addr_fault(input logic [63:0] addr,
                                        input int unsigned idx_w);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[BYTE_OFF_W-1:0] != '0);
        out_of_range = ((addr >> (idx_w + BYTE_OFF_W)) != 64'd0);
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Word-wide RAM, one synchronous write port and one synchronous read port.
// A read and write to the same word on the same edge returns the old word.
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_sync.sv
// Synchronous-read instruction memory with loader port, fault flagging and a
// post-reset clear sequencer that zeroes every word before fetches are served.
module imem_sync
    import imem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_fault,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_fault,
    output logic              init_done
);

    localparam int unsigned IDX_W       = $clog2(DEPTH);
    localparam imem_state_e RESET_STATE = CLEAR_ON_RESET ? IMEM_CLEAR : IMEM_READY;

    imem_state_e       state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_fault_q, rd_fault_d;
    logic              wr_fault_q, wr_fault_d;
    logic              init_done_q, init_done_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic              rd_bad, wr_bad;
    logic [IDX_W-1:0]  rd_idx, wr_idx;

    logic              arr_we, arr_re;
    logic [IDX_W-1:0]  arr_waddr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;

    assign rd_bad = addr_fault(64'(rd_addr), IDX_W);
    assign wr_bad = addr_fault(64'(wr_addr), IDX_W);
    assign rd_idx = IDX_W'(word_index(64'(rd_addr), IDX_W));
    assign wr_idx = IDX_W'(word_index(64'(wr_addr), IDX_W));

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (arr_we),
        .waddr  (arr_waddr),
        .wdata  (arr_wdata),
        .re     (arr_re),
        .raddr  (rd_idx),
        .rdata  (arr_rdata)
    );

    // The array port is shared: the clear sequencer owns it until READY.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        arr_we     = 1'b0;
        arr_re     = 1'b0;
        arr_waddr  = wr_idx;
        arr_wdata  = wr_data;
        rd_valid_d = 1'b0;
        rd_fault_d = 1'b0;
        wr_fault_d = 1'b0;

        unique case (state_q)
            IMEM_CLEAR: begin
                arr_we    = 1'b1;
                arr_waddr = clr_cnt_q;
                arr_wdata = '0;
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d   = IMEM_READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + IDX_W'(1);
                end
            end
            IMEM_READY: begin
                rd_valid_d = rd_req;
                rd_fault_d = rd_req & rd_bad;
                arr_re     = rd_req & ~rd_bad;
                arr_we     = wr_en & ~wr_bad;
                wr_fault_d = wr_en & wr_bad;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        init_done_d = (state_d == IMEM_READY);
    end

    // Faulting fetches return zero; idle cycles keep showing the last result.
    assign rd_data = rd_valid_q ? (rd_fault_q ? '0 : arr_rdata) : hold_q;

    always_comb begin
        hold_d = hold_q;
        if (rd_valid_q) begin
            hold_d = rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            clr_cnt_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_fault_q  <= 1'b0;
            wr_fault_q  <= 1'b0;
            init_done_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rd_valid_q  <= rd_valid_d;
            rd_fault_q  <= rd_fault_d;
            wr_fault_q  <= wr_fault_d;
            init_done_q <= init_done_d;
            hold_q      <= hold_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_fault  = rd_fault_q;
    assign wr_fault  = wr_fault_q;
    assign init_done = init_done_q;

endmodule
